// File: rtl/poly_piano_pkg.sv
// Shared types and elaboration helpers for the polyphonic piano tone generator.
package piano_pkg;

    typedef enum logic [2:0] {
        LISTEN   = 3'd0,
        GET_FREQ = 3'd1,
        READ     = 3'd2,
        SUM      = 3'd3,
        PLAY     = 3'd4
    } state_e;

    // Widest chord popcount() accepts; NUM_KEYS must not exceed this.
    localparam int MAX_KEYS = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int popcount(input logic [MAX_KEYS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/poly_piano_if.sv
// Keyboard-side and audio-side signals of poly_piano; master drives keys/tunes, slave is the generator.
interface poly_piano_if #(
    parameter int NUM_KEYS = 8,
    parameter int WAVE_W   = 8,
    parameter int PHASE_W  = 16
);
    import piano_pkg::*;

    localparam int OUT_W = WAVE_W + clog2(NUM_KEYS);
    localparam int CNT_W = clog2(NUM_KEYS + 1);

    logic [NUM_KEYS-1:0]         keys;
    logic [NUM_KEYS*PHASE_W-1:0] tune_words;
    logic [OUT_W-1:0]            wave;
    logic                        sample_valid;
    logic [CNT_W-1:0]            active_count;

    modport master (
        output keys,
        output tune_words,
        input  wave,
        input  sample_valid,
        input  active_count
    );

    modport slave (
        input  keys,
        input  tune_words,
        output wave,
        output sample_valid,
        output active_count
    );

endinterface

// File: rtl/poly_piano_sine_rom.sv
// One full sine period of 2^ROM_AW signed entries, rounded to the nearest integer; registered read.
module sine_rom #(
    parameter int ROM_AW = 6,
    parameter int WAVE_W = 8
) (
    input  logic                     clk,
    input  logic [ROM_AW-1:0]        addr,
    output logic signed [WAVE_W-1:0] data
);
    localparam int  DEPTH  = 2 ** ROM_AW;
    localparam real AMP    = real'((1 << (WAVE_W - 1)) - 1);
    localparam real TWO_PI = 6.283185307179586;

    logic signed [WAVE_W-1:0] tab_s [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        localparam real VAL  = AMP * $sin(TWO_PI * real'(k) / real'(DEPTH));
        localparam int  IVAL = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
        assign tab_s[k] = WAVE_W'(IVAL);
    end

    // Table lookup, one cycle of latency.
    always_ff @(posedge clk) begin
        data <= tab_s[addr];
    end

endmodule

// File: rtl/poly_piano.sv
// Polyphonic tone generator: per-key phase accumulators sharing one sine ROM,
// summed once per SAMPLE_DIV clocks into an offset-binary sample.
module poly_piano #(
    parameter int NUM_KEYS   = 8,
    parameter int WAVE_W     = 8,
    parameter int PHASE_W    = 16,
    parameter int ROM_AW     = 6,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic         clk,
    input  logic         rst,
    poly_piano_if.slave  bus
);
    import piano_pkg::*;

    localparam int OUT_W = WAVE_W + clog2(NUM_KEYS);
    localparam int CNT_W = clog2(NUM_KEYS + 1);
    localparam int IDX_W = (NUM_KEYS > 1) ? clog2(NUM_KEYS) : 1;
    localparam int TMR_W = clog2(SAMPLE_DIV);

    logic [NUM_KEYS-1:0]     sync1_q, sync2_q, chord_q, chord_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    tick_s;
    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        active_q, active_d;
    logic [OUT_W-1:0]        wave_q, wave_d;
    logic                    valid_q, valid_d;
    logic [PHASE_W-1:0]      phase_q [NUM_KEYS];
    logic [PHASE_W-1:0]      phase_d [NUM_KEYS];
    logic [PHASE_W-1:0]      cur_phase_s, tune_s;
    logic signed [WAVE_W-1:0] rom_data_s;

    assign cur_phase_s = phase_q[idx_q];
    assign tune_s      = bus.tune_words[int'(idx_q) * PHASE_W +: PHASE_W];
    assign tick_s      = (timer_q == TMR_W'(SAMPLE_DIV - 1));
    assign timer_d     = tick_s ? '0 : timer_q + TMR_W'(1);

    // The ROM is addressed every cycle; only the value read in READ is consumed in SUM.
    sine_rom #(
        .ROM_AW (ROM_AW),
        .WAVE_W (WAVE_W)
    ) u_rom (
        .clk  (clk),
        .addr (cur_phase_s[PHASE_W-1 -: ROM_AW]),
        .data (rom_data_s)
    );

    // Sequencer: latch chord, walk every voice through READ/SUM, then publish the sample.
    always_comb begin
        state_d  = state_q;
        chord_d  = chord_q;
        active_d = active_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        wave_d   = wave_q;
        valid_d  = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            phase_d[k] = phase_q[k];
        end
        case (state_q)
            LISTEN: begin
                if (tick_s) begin
                    state_d = GET_FREQ;
                end else begin
                    state_d = LISTEN;
                end
            end
            GET_FREQ: begin
                chord_d  = sync2_q;
                active_d = CNT_W'(popcount(MAX_KEYS'(sync2_q)));
                acc_d    = '0;
                idx_d    = '0;
                state_d  = READ;
            end
            READ: begin
                state_d = SUM;
            end
            SUM: begin
                // Released voices park at phase 0 so the next press starts a fresh cycle.
                if (chord_q[idx_q]) begin
                    acc_d          = acc_q + OUT_W'(rom_data_s);
                    phase_d[idx_q] = cur_phase_s + tune_s;
                end else begin
                    phase_d[idx_q] = '0;
                end
                if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                    state_d = PLAY;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = READ;
                end
            end
            PLAY: begin
                wave_d  = {~acc_q[OUT_W-1], acc_q[OUT_W-2:0]};
                valid_d = 1'b1;
                state_d = LISTEN;
            end
            default: begin
                state_d = LISTEN;
            end
        endcase
    end

    // State registers with asynchronous reset to silence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            chord_q  <= '0;
            timer_q  <= '0;
            state_q  <= LISTEN;
            idx_q    <= '0;
            acc_q    <= '0;
            active_q <= '0;
            wave_q   <= {1'b1, {(OUT_W-1){1'b0}}};
            valid_q  <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                phase_q[k] <= '0;
            end
        end else begin
            sync1_q  <= bus.keys;
            sync2_q  <= sync1_q;
            chord_q  <= chord_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            active_q <= active_d;
            wave_q   <= wave_d;
            valid_q  <= valid_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                phase_q[k] <= phase_d[k];
            end
        end
    end

    assign bus.wave         = wave_q;
    assign bus.sample_valid = valid_q;
    assign bus.active_count = active_q;

endmodule

// File: tb/tb_poly_piano.sv
// Directed and randomized checks of poly_piano against a per-voice arithmetic model.
module tb_poly_piano;

    localparam int NK   = 8;
    localparam int WW   = 8;
    localparam int PW   = 16;
    localparam int AW   = 6;
    localparam int DIV  = 1024;
    localparam int OW   = 11;
    localparam int LAT  = 2 * NK + 3;
    localparam int MIDW = 1009;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_piano_if #(.NUM_KEYS(NK), .WAVE_W(WW), .PHASE_W(PW)) bus ();

    poly_piano #(
        .NUM_KEYS   (NK),
        .WAVE_W     (WW),
        .PHASE_W    (PW),
        .ROM_AW     (AW),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int ref_phase [NK];
    int ref_tune  [NK];

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int sine_ref(input int a);
        real v;
        v = 127.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 64.0);
        return $rtoi($floor(v + 0.5));
    endfunction

    // One output sample: every pressed voice contributes sin(phase) then advances; others restart.
    task automatic model_step(input logic [NK-1:0] chord, output int w);
        int s;
        s = 0;
        for (int k = 0; k < NK; k++) begin
            if (chord[k]) begin
                s = s + sine_ref(ref_phase[k] / (1 << (PW - AW)));
                ref_phase[k] = (ref_phase[k] + ref_tune[k]) % (1 << PW);
            end else begin
                ref_phase[k] = 0;
            end
        end
        w = s + (1 << (OW - 1));
    endtask

    task automatic set_tune(input int k, input int t);
        bus.tune_words[k*PW +: PW] = PW'(t);
        ref_tune[k] = t;
    endtask

    task automatic wait_sample(output int ncyc);
        ncyc = 0;
        do begin
            @(posedge clk);
            #1;
            ncyc++;
        end while (bus.sample_valid !== 1'b1 && ncyc < DIV + LAT + 16);
        check("valid_seen", int'(bus.sample_valid), 1);
    endtask

    task automatic take_sample(input string tag, input logic [NK-1:0] chord,
                               input int exp_const, output int ncyc);
        int w;
        wait_sample(ncyc);
        model_step(chord, w);
        if (exp_const >= 0) check({tag, "_const"}, int'(bus.wave), exp_const);
        check({tag, "_wave"}, int'(bus.wave), w);
        check({tag, "_active"}, int'(bus.active_count), $countones(chord));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, int'(bus.sample_valid), 0);
    endtask

    task automatic reset_model();
        for (int k = 0; k < NK; k++) ref_phase[k] = 0;
    endtask

    initial begin
        int n;
        logic [NK-1:0] kr;

        bus.keys = '0;
        bus.tune_words = '0;
        for (int k = 0; k < NK; k++) set_tune(k, 16384);
        reset_model();

        // Reset state, then first-sample timing with silence.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wave", int'(bus.wave), 1024);
        check("rst_valid", int'(bus.sample_valid), 0);
        check("rst_active", int'(bus.active_count), 0);
        @(negedge clk);
        rst = 1'b0;
        take_sample("first", 8'h00, 1024, n);
        check("first_latency", n, DIV - 1 + LAT);

        // Single key at quarter-period tuning.
        bus.keys = 8'h01;
        take_sample("k0_a", 8'h01, 1024, n);
        take_sample("k0_b", 8'h01, 1151, n);
        take_sample("k0_c", 8'h01, 1024, n);
        take_sample("k0_d", 8'h01, 897, n);
        take_sample("k0_e", 8'h01, 1024, n);

        // Full chord from phase 0.
        bus.keys = 8'h00;
        take_sample("clr", 8'h00, 1024, n);
        bus.keys = 8'hFF;
        take_sample("all_a", 8'hFF, 1024, n);
        take_sample("all_b", 8'hFF, 2040, n);
        take_sample("all_c", 8'hFF, 1024, n);
        take_sample("all_d", 8'hFF, 8, n);

        // Release and re-press restarts the phase.
        bus.keys = 8'h00;
        take_sample("rel0", 8'h00, 1024, n);
        bus.keys = 8'h01;
        take_sample("p1_a", 8'h01, 1024, n);
        take_sample("p1_b", 8'h01, 1151, n);
        bus.keys = 8'h00;
        take_sample("rel1", 8'h00, 1024, n);
        bus.keys = 8'h01;
        take_sample("p2_a", 8'h01, 1024, n);
        take_sample("p2_b", 8'h01, 1151, n);
        take_sample("p2_c", 8'h01, 1024, n);

        // Release inside READ/SUM: the sample in flight still uses the latched chord.
        repeat (MIDW) @(posedge clk);
        #2 bus.keys = 8'h00;
        take_sample("tog_same", 8'h01, 897, n);
        take_sample("tog_next", 8'h00, 1024, n);

        // Random chords and tunings against the model.
        for (int k = 0; k < NK; k++) set_tune(k, int'($urandom_range(0, 65535)));
        for (int i = 0; i < 12; i++) begin
            kr = NK'($urandom);
            bus.keys = kr;
            take_sample("rand", kr, -1, n);
        end

        // Asynchronous reset in the middle of SUM.
        for (int k = 0; k < NK; k++) set_tune(k, 16384);
        bus.keys = 8'h01;
        repeat (MIDW) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wave", int'(bus.wave), 1024);
        check("mid_rst_valid", int'(bus.sample_valid), 0);
        check("mid_rst_active", int'(bus.active_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        take_sample("post_rst_a", 8'h01, 1024, n);
        check("post_rst_latency", n, DIV - 1 + LAT);
        take_sample("post_rst_b", 8'h01, 1151, n);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/poly_piano.md
Name: poly_piano

Overview:
- Parametrised polyphonic successor to the 8-key piano tone generator.
- Samples NUM_KEYS key inputs once per audio sample period and gives each key its own phase accumulator with a per-key tuning word.
- Time-multiplexes one shared sine ROM across all voices, sums the pressed voices and emits one offset-binary audio sample per period with a valid strobe.
- Sits between the keyboard inputs and the DAC/PWM output stage.

Parameters:
- NUM_KEYS, 8: number of keys/voices; must be >=1.
- WAVE_W, 8: signed ROM sample width.
- PHASE_W, 16: phase accumulator and tuning word width.
- ROM_AW, 6: sine ROM address bits; ROM_AW <= PHASE_W.
- SAMPLE_DIV, 1024: clocks per output sample; must be >= 2*NUM_KEYS+4.
- OUT_W (derived): WAVE_W + clog2(NUM_KEYS); 11 at the defaults.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- keys, input, NUM_KEYS: asynchronous key levels; bit i = key i pressed.
- tune_words, input, NUM_KEYS*PHASE_W: per-key phase increment; key i occupies bits [i*PHASE_W +: PHASE_W]. Must be quasi-static.
- wave, output, OUT_W: offset-binary audio sample.
- sample_valid, output, 1: one-cycle pulse when wave updates.
- active_count, output, clog2(NUM_KEYS+1): number of keys in the latched chord.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - wave = 2^(OUT_W-1) (silence; 1024 at defaults).
  - sample_valid = 0, active_count = 0.
  - All phase accumulators, chord register, accumulator, timer and voice index = 0.
  - Key synchroniser flops = 0; FSM = LISTEN.
- Key synchroniser: 2-flop per bit. The chord register sees a key change no earlier than 2 cycles after it occurs.
- Sample timer:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = 1 when count == SAMPLE_DIV-1, so the first tick comes SAMPLE_DIV cycles after reset release.
- FSM:
  - LISTEN: wait for tick. tick -> GET_FREQ.
  - GET_FREQ: latch chord <= synced keys; active_count <= popcount(synced keys); acc <= 0; idx <= 0. -> READ.
  - READ: ROM address = phase[idx][PHASE_W-1 -: ROM_AW]. -> SUM.
  - SUM (ROM data valid, 1-cycle registered ROM):
    - If chord[idx]: acc += sign-extended rom_data and phase[idx] += tune[idx] (mod 2^PHASE_W).
    - Else: acc unchanged and phase[idx] <= 0, so a note always restarts at phase 0.
    - idx == NUM_KEYS-1 -> PLAY; else idx++ and -> READ.
  - PLAY: wave <= acc with MSB inverted (acc + 2^(OUT_W-1)); sample_valid <= 1 for the next cycle only. -> LISTEN.
- Latency: tick at cycle t -> new wave and sample_valid=1 at t+2*NUM_KEYS+3 (19 cycles at defaults). wave holds until the next PLAY.
- Arithmetic: acc is signed OUT_W and cannot overflow (NUM_KEYS*(2^(WAVE_W-1)-1) fits). Phase accumulators wrap silently.
- A tick outside LISTEN is ignored; this is unreachable given the SAMPLE_DIV constraint.
- Key changes during READ/SUM do not affect the current sample; the chord is latched only in GET_FREQ.
- Reset mid-operation: all state returns to the reset values immediately. No sample_valid until a full SAMPLE_DIV after release.

Decomposition:
- Package piano_pkg holds:
  - state enum LISTEN/GET_FREQ/READ/SUM/PLAY;
  - clog2 function;
  - popcount function.
- Sub-module sine_rom (params ROM_AW, WAVE_W; ports clk, addr, data):
  - Registered output, no reset.
  - Entry k = round((2^(WAVE_W-1)-1)*sin(2*pi*k/2^ROM_AW)).
  - At defaults: entry 0 = 0, entry 16 = 127, entry 48 = -127.

Test Plan:
- Reset with keys=0 -> wave=1024, sample_valid=0, active_count=0; first sample_valid exactly 1024+19 cycles after release; wave stays 1024.
- Key0 held, tune0=16384, defaults -> successive samples 1024, 1151, 1024, 897, repeating; active_count=1.
- All 8 keys held, all tunes=16384 -> samples 1024, 2040, 1024, 8; active_count=8.
- Key0 held for 2 samples (1024, 1151), released for 1 sample (1024), re-pressed -> next samples restart 1024, 1151 (phase reset).
- Key toggled during READ/SUM of a sample -> that sample unaffected; change appears no earlier than the following sample.
- rst asserted mid-SUM -> wave=1024 and sample_valid=0 in the same cycle, asynchronously; after release, the next sample_valid comes 1024+19 cycles later with phase restarted at 0.
